// File: rtl/pid_sample_sequencer.sv
// pid_sample_sequencer: sample-period divider and ADC/ek/ik strobe sequencer for the PID integral path
module pid_sample_sequencer #(
  parameter int DIV_W       = 16,
  parameter int PIPE_LAT    = 3,
  parameter int TO_W        = 8,
  parameter int ADC_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             adc_ready,
  input  logic             clr_flags,
  output logic             adc_start,
  output logic             en1,
  output logic             en2,
  output logic             busy,
  output logic             sample_done,
  output logic             overrun,
  output logic             timeout
);
  localparam int SW = $clog2(PIPE_LAT + 2);
  typedef enum logic [2:0] {IDLE, CONVERT, LOAD, SETTLE, UPDATE, DONE} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [TO_W-1:0] to_q, to_d;
  logic [SW-1:0] st_q, st_d;
  logic run_q, run_rise, tick, to_hit;
  logic adc_start_q, adc_start_d, en1_q, en1_d, en2_q, en2_d, busy_q, busy_d;
  logic sample_done_q, sample_done_d, overrun_q, overrun_d, timeout_q, timeout_d;
  always_comb begin
    run_rise = run && !run_q;
    div_eff = run_rise ? div : div_q;
    tick = run && cnt_q == div_eff;
    cnt_d = run && !tick ? cnt_q + 1'b1 : '0;
    div_d = run_rise || tick ? div : div_q;
    state_d = state_q;
    to_d = to_q;
    st_d = st_q;
    to_hit = 1'b0;
    case (state_q)
      IDLE: begin
        to_d = '0;
        state_d = tick ? CONVERT : IDLE;
      end
      CONVERT:
        if (adc_ready && !adc_start_q) state_d = LOAD;
        else if (to_q == TO_W'(ADC_TIMEOUT)) begin
          state_d = IDLE;
          to_hit = 1'b1;
        end else to_d = to_q + 1'b1;
      LOAD: begin
        st_d = '0;
        state_d = PIPE_LAT == 0 ? UPDATE : SETTLE;
      end
      SETTLE:
        if (st_q == SW'(PIPE_LAT - 1)) state_d = UPDATE;
        else st_d = st_q + 1'b1;
      UPDATE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    adc_start_d = state_q == IDLE && tick;
    en1_d = state_d == LOAD;
    en2_d = state_d == UPDATE;
    sample_done_d = state_d == DONE;
    busy_d = state_d != IDLE;
    overrun_d = (tick && state_q != IDLE) || (overrun_q && !clr_flags);
    timeout_d = to_hit || (timeout_q && !clr_flags);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      to_q <= '0;
      st_q <= '0;
      run_q <= 1'b0;
      adc_start_q <= 1'b0;
      en1_q <= 1'b0;
      en2_q <= 1'b0;
      busy_q <= 1'b0;
      sample_done_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      to_q <= to_d;
      st_q <= st_d;
      run_q <= run;
      adc_start_q <= adc_start_d;
      en1_q <= en1_d;
      en2_q <= en2_d;
      busy_q <= busy_d;
      sample_done_q <= sample_done_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end
  assign adc_start = adc_start_q;
  assign en1 = en1_q;
  assign en2 = en2_q;
  assign busy = busy_q;
  assign sample_done = sample_done_q;
  assign overrun = overrun_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_pid_sample_sequencer.sv
// tb_pid_sample_sequencer: scoreboard bench checking strobe timing and flags of pid_sample_sequencer
module tb_pid_sample_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, run, adc_ready, clr_flags;
  logic [15:0] div;
  logic adc_start, en1, en2, busy, sample_done, overrun, timeout;
  logic reset_t, run_t, adc_ready_t, clr_t;
  logic [15:0] div_t;
  logic adc_start_t, en1_t, en2_t, busy_t, sample_done_t, overrun_t, timeout_t;
  pid_sample_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .div(div), .adc_ready(adc_ready), .clr_flags(clr_flags),
    .adc_start(adc_start), .en1(en1), .en2(en2), .busy(busy), .sample_done(sample_done),
    .overrun(overrun), .timeout(timeout)
  );
  pid_sample_sequencer #(.ADC_TIMEOUT(8)) dut_t (
    .clk(clk), .reset(reset_t), .run(run_t), .div(div_t), .adc_ready(adc_ready_t), .clr_flags(clr_t),
    .adc_start(adc_start_t), .en1(en1_t), .en2(en2_t), .busy(busy_t), .sample_done(sample_done_t),
    .overrun(overrun_t), .timeout(timeout_t)
  );
  typedef struct {int c; int k;} ev_t;
  ev_t exp_q[$];
  ev_t e_m;
  logic [3:0] strobes;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int en_cnt_t = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask
  task automatic expect_ev(input int c, input int k);
    ev_t e;
    e.c = c;
    e.k = k;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    strobes = {sample_done, en2, en1, adc_start};
    for (int k = 0; k < 4; k++)
      if (strobes[k]) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected strobe %0d @cyc %0d: got 1, expected none", k, cyc);
        end else begin
          e_m = exp_q.pop_front();
          chk("strobe kind", k, e_m.k);
          chk("strobe cycle", cyc, e_m.c);
        end
      end
    if (en1_t || en2_t) en_cnt_t++;
  end
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic pulse_ready(input int c);
    wait_to(c);
    adc_ready = 1'b1;
    @(negedge clk);
    adc_ready = 1'b0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    run = 1'b0;
    adc_ready = 1'b0;
    clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk1("reset outputs", |{adc_start, en1, en2, busy, sample_done, overrun, timeout}, 1'b0);
  endtask
  task automatic scen1;
    int c0;
    do_reset;
    c0 = cyc;
    div = 9;
    run = 1'b1;
    expect_ev(c0 + 10, 0); expect_ev(c0 + 13, 1); expect_ev(c0 + 17, 2); expect_ev(c0 + 18, 3);
    expect_ev(c0 + 20, 0); expect_ev(c0 + 23, 1); expect_ev(c0 + 27, 2); expect_ev(c0 + 28, 3);
    wait_to(c0 + 10);
    chk1("s1 busy at start", busy, 1'b1);
    pulse_ready(c0 + 12);
    wait_to(c0 + 19);
    chk1("s1 idle after done", busy, 1'b0);
    pulse_ready(c0 + 22);
    wait_to(c0 + 24);
    run = 1'b0;
    wait_to(c0 + 35);
    chk1("s1 overrun", overrun, 1'b0);
    chk("s1 queue drained", exp_q.size(), 0);
  endtask
  task automatic scen2;
    int c0;
    do_reset;
    c0 = cyc;
    div = 2;
    run = 1'b1;
    expect_ev(c0 + 3, 0); expect_ev(c0 + 14, 1); expect_ev(c0 + 18, 2); expect_ev(c0 + 19, 3);
    expect_ev(c0 + 21, 0); expect_ev(c0 + 32, 1); expect_ev(c0 + 36, 2); expect_ev(c0 + 37, 3);
    wait_to(c0 + 5);
    chk1("s2 overrun before tick", overrun, 1'b0);
    wait_to(c0 + 6);
    chk1("s2 overrun set", overrun, 1'b1);
    wait_to(c0 + 8);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk1("s2 set beats clr", overrun, 1'b1);
    wait_to(c0 + 12);
    chk1("s2 busy waiting adc", busy, 1'b1);
    pulse_ready(c0 + 13);
    pulse_ready(c0 + 31);
    wait_to(c0 + 33);
    run = 1'b0;
    wait_to(c0 + 40);
    chk1("s2 overrun sticky", overrun, 1'b1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk1("s2 overrun cleared", overrun, 1'b0);
    chk("s2 queue drained", exp_q.size(), 0);
  endtask
  task automatic scen3;
    int c0;
    reset_t = 1'b1;
    repeat (2) @(negedge clk);
    reset_t = 1'b0;
    c0 = cyc;
    en_cnt_t = 0;
    div_t = 19;
    run_t = 1'b1;
    wait_to(c0 + 20);
    chk1("s3 adc_start", adc_start_t, 1'b1);
    wait_to(c0 + 28);
    chk1("s3 busy before timeout", busy_t, 1'b1);
    chk1("s3 no timeout yet", timeout_t, 1'b0);
    wait_to(c0 + 29);
    chk1("s3 timeout set", timeout_t, 1'b1);
    chk1("s3 busy after timeout", busy_t, 1'b0);
    wait_to(c0 + 40);
    chk1("s3 restart adc_start", adc_start_t, 1'b1);
    chk("s3 no en1/en2 on timeout", en_cnt_t, 0);
    wait_to(c0 + 42);
    adc_ready_t = 1'b1;
    @(negedge clk);
    adc_ready_t = 1'b0;
    chk1("s3 restart en1", en1_t, 1'b1);
    run_t = 1'b0;
    wait_to(c0 + 47);
    chk1("s3 restart en2", en2_t, 1'b1);
    wait_to(c0 + 48);
    chk1("s3 restart sample_done", sample_done_t, 1'b1);
    chk("s3 strobe count", en_cnt_t, 2);
    wait_to(c0 + 49);
    clr_t = 1'b1;
    @(negedge clk);
    clr_t = 1'b0;
    chk1("s3 timeout cleared", timeout_t, 1'b0);
  endtask
  task automatic scen4;
    int c0;
    do_reset;
    c0 = cyc;
    div = 9;
    run = 1'b1;
    expect_ev(c0 + 10, 0); expect_ev(c0 + 13, 1);
    pulse_ready(c0 + 12);
    wait_to(c0 + 15);
    chk1("s4 busy in settle", busy, 1'b1);
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk1("s4 outputs after reset", |{adc_start, en1, en2, busy, sample_done, overrun, timeout}, 1'b0);
    wait_to(c0 + 30);
    chk("s4 queue drained", exp_q.size(), 0);
    scen1;
  endtask
  task automatic scen5;
    int c0;
    do_reset;
    c0 = cyc;
    div = 9;
    run = 1'b1;
    expect_ev(c0 + 10, 0); expect_ev(c0 + 14, 1); expect_ev(c0 + 18, 2); expect_ev(c0 + 19, 3);
    wait_to(c0 + 11);
    run = 1'b0;
    pulse_ready(c0 + 13);
    wait_to(c0 + 19);
    chk1("s5 busy in done", busy, 1'b1);
    wait_to(c0 + 70);
    chk1("s5 idle", busy, 1'b0);
    chk("s5 queue drained", exp_q.size(), 0);
  endtask
  task automatic scen6;
    int c0;
    do_reset;
    c0 = cyc;
    div = 9;
    run = 1'b1;
    expect_ev(c0 + 10, 0); expect_ev(c0 + 12, 1); expect_ev(c0 + 16, 2); expect_ev(c0 + 17, 3);
    expect_ev(c0 + 20, 0); expect_ev(c0 + 22, 1); expect_ev(c0 + 26, 2); expect_ev(c0 + 27, 3);
    wait_to(c0 + 5);
    div = 4;
    pulse_ready(c0 + 11);
    wait_to(c0 + 14);
    chk1("s6 no overrun before short tick", overrun, 1'b0);
    wait_to(c0 + 15);
    chk1("s6 overrun from 5-cycle tick", overrun, 1'b1);
    pulse_ready(c0 + 21);
    wait_to(c0 + 26);
    run = 1'b0;
    wait_to(c0 + 35);
    chk("s6 queue drained", exp_q.size(), 0);
  endtask
  task automatic scen7;
    int c0;
    do_reset;
    c0 = cyc;
    div = 0;
    run = 1'b1;
    expect_ev(c0 + 1, 0); expect_ev(c0 + 3, 1); expect_ev(c0 + 7, 2); expect_ev(c0 + 8, 3);
    wait_to(c0 + 1);
    chk1("s7 overrun after first tick", overrun, 1'b0);
    adc_ready = 1'b1;
    wait_to(c0 + 2);
    chk1("s7 overrun div0", overrun, 1'b1);
    wait_to(c0 + 3);
    adc_ready = 1'b0;
    wait_to(c0 + 5);
    run = 1'b0;
    wait_to(c0 + 15);
    chk("s7 queue drained", exp_q.size(), 0);
  endtask
  initial begin
    reset_t = 1'b1;
    run_t = 1'b0;
    div_t = 0;
    adc_ready_t = 1'b0;
    clr_t = 1'b0;
    div = 0;
    scen1;
    scen2;
    scen3;
    scen4;
    scen5;
    scen6;
    scen7;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end
endmodule

// File: doc/pid_sample_sequencer.md
Name: pid_sample_sequencer

Overview:
Sample-rate sequencer for the fixed-point PID integral path (N-bit error ek, integrator accumulator ik).
- Divides clk into a programmable sample period.
- Starts an ADC conversion and waits for its ready handshake.
- Pulses en1 to capture ek, waits for the integrator pipeline to settle, then pulses en2 exactly once so ik accumulates exactly once per sample.
- Flags overrun and ADC timeout; sits between the ADC interface and the ik/PID datapath.

Parameters:
DIV_W, 16, width of sample-period divider
PIPE_LAT, 3, settle cycles between en1 and en2 (register stages from ek capture to accumulator input)
TO_W, 8, width of ADC timeout counter
ADC_TIMEOUT, 200, max cycles to wait for adc_ready after adc_start

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
run  in  1  1 = sequencing enabled
div  in  DIV_W  sample period minus one (period = div+1 cycles)
adc_ready  in  1  ADC conversion complete (level or pulse)
clr_flags  in  1  clears overrun and timeout flags
adc_start  out  1  one-cycle conversion request
en1  out  1  one-cycle capture strobe for ek
en2  out  1  one-cycle accumulator update strobe (ik register enable)
busy  out  1  sample sequence in progress
sample_done  out  1  one-cycle pulse; ik holds the new value
overrun  out  1  sticky; tick arrived while busy
timeout  out  1  sticky; ADC failed to respond

Behaviour:
Reset:
- All outputs 0; state IDLE; cnt = 0; div_q = 0; timeout counter = 0.
- Reset mid-sequence aborts without issuing en1/en2.

Divider:
- cnt increments each cycle while run=1.
- When cnt == div_q: tick=1 that cycle, cnt <= 0, div_q <= div.
- run=0: cnt <= 0, no ticks.
- On the run 0->1 edge, div_q <= div.
- div changes take effect only at the run edge or at a wrap.

FSM states: IDLE, CONVERT, LOAD, SETTLE, UPDATE, DONE.
- IDLE: on tick -> CONVERT. adc_start=1 in the first CONVERT cycle only.
- CONVERT:
  - adc_ready is ignored in the adc_start cycle.
  - adc_ready=1 on any later cycle -> LOAD.
  - If the timeout counter reaches ADC_TIMEOUT first -> IDLE; set timeout; no en1/en2.
- LOAD: en1=1 for one cycle -> SETTLE.
- SETTLE: exactly PIPE_LAT cycles (PIPE_LAT=0 skips it) -> UPDATE.
- UPDATE: en2=1 for one cycle -> DONE.
- DONE: sample_done=1 for one cycle -> IDLE.

Latency and strobes:
- tick at T -> adc_start at T+1.
- adc_ready at R -> en1 at R+1, en2 at R+2+PIPE_LAT, sample_done at R+3+PIPE_LAT.
- busy=1 in every non-IDLE state.
- adc_start, en1, en2 and sample_done are mutually exclusive and never wider than one cycle.

Boundary conditions:
- Tick while state != IDLE (including the DONE cycle): tick dropped, overrun <= 1, current sequence unaffected.
- run falls mid-sequence: the sequence completes; no new ticks.
- div=0: tick every cycle while run=1; overrun is expected.
- clr_flags clears overrun and timeout. If it coincides with a set event, set wins.
- Only en2 advances the accumulator, so ik changes at most once per tick.

Test Plan:
1. reset, run=1 at cycle 0, div=9, PIPE_LAT=3, adc_ready pulsed 2 cycles after adc_start -> tick at 9, adc_start 10, en1 13, en2 17, sample_done 18, next adc_start 20; overrun=0.
2. div=2, adc_ready delayed 10 cycles -> overrun=1 on the first tick inside CONVERT, exactly one en2 per completed sequence; clr_flags -> overrun=0.
3. ADC_TIMEOUT=8, adc_ready held 0 -> timeout=1, state back to IDLE, en1/en2 never asserted, busy=0; next tick restarts normally.
4. reset asserted during SETTLE -> next cycle all outputs 0, no en2 issued; re-run with div=9 reproduces scenario 1 timing.
5. run dropped 1 cycle after adc_start -> en1, en2 and sample_done still issued; no further adc_start for 50 cycles.
6. div changed from 9 to 4 mid-period -> current period stays 10 cycles, subsequent periods 5 cycles.
